// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues credit-limited word fetches, buffers
// returned words with their PC for decode, and squashes wrong-path fetches on redirect.

// Generic flushable FIFO.
// Latency: a pushed entry is visible at the head the following cycle.
// Backpressure: rd_rdy_i pops the head; a push while full is ignored unless a pop coincides.
module ifu_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   wr_vld_i,
  input  logic [WIDTH-1:0]       wr_dat_i,
  input  logic                   rd_rdy_i,
  output logic                   rd_vld_o,
  output logic [WIDTH-1:0]       rd_dat_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en, rd_en;

  always_comb begin
    rd_en    = rd_rdy_i && (count_q != '0);
    wr_en    = wr_vld_i && ((count_q != (AW+1)'(DEPTH)) || rd_en);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q] = wr_dat_i;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_vld_o = (count_q != '0);
  assign rd_dat_o = mem_q[rd_ptr_q];
  assign count_o  = count_q;
endmodule

// Instruction fetch unit top.
// Latency: grant at cycle n, response at n+1, instruction valid to decode at n+2.
// Backpressure: fetch requests stop once outstanding + dropping + buffered reaches FIFO_DEPTH.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic [6:0]  opcode_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ibuf_t;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic          run_q, run_d;

  logic [CW-1:0] live_cnt, buf_cnt;
  logic [CW+1:0] inflight;
  logic          grant, rsp, rsp_drop, rsp_live;
  logic          tag_vld;
  logic [31:0]   tag_pc;
  logic          buf_vld;
  ibuf_t         buf_in, buf_head;
  logic          unused_redirect_lsb;

  // live_cnt is the occupancy of the PC tag queue: one tag per live outstanding request
  assign inflight   = (CW+2)'(live_cnt) + (CW+2)'(drop_cnt_q) + (CW+2)'(buf_cnt);
  assign imem_req_o = run_q && (inflight < (CW+2)'(FIFO_DEPTH));
  assign imem_addr_o = pc_q;
  assign grant      = imem_req_o && imem_gnt_i;

  assign rsp      = imem_rvalid_i && ((live_cnt != '0) || (drop_cnt_q != '0));
  assign rsp_drop = rsp && !redirect_i && (drop_cnt_q != '0);
  assign rsp_live = rsp && !redirect_i && (drop_cnt_q == '0) && tag_vld;

  assign buf_in.instr = imem_rdata_i;
  assign buf_in.pc    = tag_pc;

  always_comb begin
    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;
    run_d      = 1'b1;
    if (redirect_i) begin
      pc_d       = {redirect_pc_i[31:2], 2'b00};
      drop_cnt_d = drop_cnt_q + live_cnt + CW'(grant) - CW'(rsp);
    end else begin
      if (grant) begin
        pc_d = pc_q + 32'd4;
      end
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
      run_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
      run_q      <= run_d;
    end
  end

  ifu_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_q (
    .clk      (clk),
    .reset    (reset),
    .flush_i  (redirect_i),
    .wr_vld_i (grant && !redirect_i),
    .wr_dat_i (pc_q),
    .rd_rdy_i (rsp_live),
    .rd_vld_o (tag_vld),
    .rd_dat_o (tag_pc),
    .count_o  (live_cnt)
  );

  ifu_fifo #(
    .WIDTH ($bits(ibuf_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_ibuf (
    .clk      (clk),
    .reset    (reset),
    .flush_i  (redirect_i),
    .wr_vld_i (rsp_live),
    .wr_dat_i (buf_in),
    .rd_rdy_i (instr_ready_i),
    .rd_vld_o (buf_vld),
    .rd_dat_o (buf_head),
    .count_o  (buf_cnt)
  );

  assign instr_valid_o = buf_vld;
  assign instr_o       = buf_vld ? buf_head.instr : NOP_INSTR;
  assign instr_pc_o    = buf_vld ? buf_head.pc : 32'd0;
  assign opcode_o      = instr_o[6:0];

  assign unused_redirect_lsb = ^redirect_pc_i[1:0];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a memory model answers fetches with ~addr, and a
// monitor pops the expected PC stream on every decode transfer.
module tb_instr_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic [6:0]  opcode_o;

  instr_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .opcode_o      (opcode_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc = RST_PC;
  bit          flush_pend = 1'b0;
  bit          gnt_en = 1'b0, rsp_en = 1'b0, rdy = 1'b0;
  logic [31:0] mon_e, mon_ei;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One cycle: inputs change on the falling edge and are sampled by the next rising edge.
  task automatic step(input bit redir, input logic [31:0] rpc, output bit g, output logic [31:0] ga);
    logic [31:0] a;
    @(negedge clk);
    if (flush_pend) begin
      exp_q.delete();
      flush_pend = 1'b0;
    end
    if (rsp_en && mem_q.size() > 0) begin
      a = mem_q.pop_front();
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = ~a;
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
    end
    imem_gnt_i    = gnt_en;
    instr_ready_i = rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    g  = imem_req_o && gnt_en;
    ga = imem_addr_o;
    if (g) begin
      chk("fetch_addr", imem_addr_o, exp_pc);
      mem_q.push_back(imem_addr_o);
      if (!redir) exp_q.push_back(exp_pc);
      exp_pc = exp_pc + 32'd4;
    end
    if (redir) begin
      exp_pc     = {rpc[31:2], 2'b00};
      flush_pend = 1'b1;
    end
  endtask

  task automatic run(input int n);
    bit g;
    logic [31:0] ga;
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, g, ga);
  endtask

  task automatic drain();
    gnt_en = 1'b0; rsp_en = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) run(1);
    run(3);
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; instr_ready_i = 1'b0;
    redirect_i = 1'b0; gnt_en = 1'b0; rsp_en = 1'b0; rdy = 1'b0;
    mem_q.delete(); exp_q.delete(); flush_pend = 1'b0; exp_pc = RST_PC;
    @(negedge clk);
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o, NOP);
    chk("rst_pc", instr_pc_o, 32'd0);
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_opcode", {25'd0, opcode_o}, 32'h13);
    reset = 1'b0;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        if (instr_valid_o && instr_ready_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_instr actual_pc=%h required=none", instr_pc_o);
          end else begin
            mon_e  = exp_q.pop_front();
            mon_ei = ~mon_e;
            chk("instr_pc", instr_pc_o, mon_e);
            chk("instr_word", instr_o, mon_ei);
            chk("opcode", {25'd0, opcode_o}, {25'd0, mon_ei[6:0]});
          end
        end else if (!instr_valid_o) begin
          chk("idle_nop", instr_o, NOP);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit g;
    logic [31:0] ga;
    int first_g, first_v, xfers, grants;

    do_reset();

    // Zero-wait streaming: first valid two cycles after first grant, then one per cycle
    gnt_en = 1'b1; rsp_en = 1'b1; rdy = 1'b1;
    first_g = -1; first_v = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 32'd0, g, ga);
      if (g && first_g < 0) first_g = i;
      if (instr_valid_o && first_v < 0) begin
        first_v = i;
        chk("first_pc", instr_pc_o, 32'h0040_0000);
      end
    end
    chk("first_latency", 32'(first_v - first_g), 32'd2);
    xfers = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 32'd0, g, ga);
      if (instr_valid_o && instr_ready_i) xfers++;
    end
    chk("throughput", 32'(xfers), 32'd20);

    // Decode stall: credit caps the buffered + outstanding words at four
    rdy = 1'b0;
    run(8);
    chk("stall_req", {31'd0, imem_req_o}, 32'd0);
    chk("stall_valid", {31'd0, instr_valid_o}, 32'd1);
    chk("stall_buffered", 32'(exp_q.size()), 32'd4);
    drain();

    // Two outstanding then redirect to an unaligned target
    gnt_en = 1'b1; rsp_en = 1'b0; rdy = 1'b1;
    grants = 0;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 32'd0, g, ga);
      if (g) grants++;
    end
    chk("pre_redirect_grants", 32'(grants), 32'd2);
    gnt_en = 1'b0;
    step(1'b1, 32'h0040_0103, g, ga);
    gnt_en = 1'b1; rsp_en = 1'b1;
    first_g = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'd0, g, ga);
      if (g && first_g < 0) begin
        first_g = i;
        chk("redirect_addr", ga, 32'h0040_0100);
      end
      if (instr_valid_o) begin
        chk("redirect_first_pc", instr_pc_o, 32'h0040_0100);
        break;
      end
    end
    drain();

    // Redirect in a cycle that also carries a grant and a response
    gnt_en = 1'b1; rsp_en = 1'b1; rdy = 1'b1;
    run(5);
    step(1'b1, 32'h0040_0200, g, ga);
    chk("redirect_cycle_grant", {31'd0, g}, 32'd1);
    chk("redirect_cycle_rvalid", {31'd0, imem_rvalid_i}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'd0, g, ga);
      if (instr_valid_o) begin
        chk("redirect2_first_pc", instr_pc_o, 32'h0040_0200);
        break;
      end
    end
    drain();

    // Fill the buffer, then reset mid-stream
    gnt_en = 1'b1; rsp_en = 1'b1; rdy = 1'b0;
    run(8);
    chk("full_valid", {31'd0, instr_valid_o}, 32'd1);
    chk("full_req", {31'd0, imem_req_o}, 32'd0);
    do_reset();

    // Grant stall after two fetches: address held at 0x400008
    gnt_en = 1'b1; rsp_en = 1'b1; rdy = 1'b1;
    grants = 0;
    for (int i = 0; i < 10 && grants < 2; i++) begin
      step(1'b0, 32'd0, g, ga);
      if (g) begin
        if (grants == 0) chk("post_reset_addr", ga, 32'h0040_0000);
        grants++;
      end
    end
    chk("post_reset_grants", 32'(grants), 32'd2);
    gnt_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run(1);
      chk("gnt_stall_req", {31'd0, imem_req_o}, 32'd1);
      chk("gnt_stall_addr", imem_addr_o, 32'h0040_0008);
    end
    gnt_en = 1'b1;
    step(1'b0, 32'd0, g, ga);
    chk("resume_grant", {31'd0, g}, 32'd1);
    chk("resume_addr", ga, 32'h0040_0008);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
